// File: rtl/speck_round_sched.sv
// Iterative SPECK32/64 controller: one shared round plus an on-the-fly key schedule.
// Optional decrypt support (KEYEXP state + round-key file) is built when SPECK_DECRYPT_EN is defined.
module speck_round_sched #(
    parameter int unsigned ROUNDS = 22,
    parameter int unsigned ALPHA  = 7,
    parameter int unsigned BETA   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_dec,
    input  logic [63:0] in_key,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
`ifdef SPECK_DECRYPT_EN
        KEYEXP,
`endif
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] RC_LAST  = 5'(ROUNDS - 1);
    localparam logic [4:0] RC_KLAST = 5'(ROUNDS - 2);

    state_t      state;
    state_t      state_nxt;
    state_t      start_state;

    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] k;
    logic [15:0] l0;
    logic [15:0] l1;
    logic [15:0] l2;
    logic [4:0]  rc;

    logic [15:0] enc_x;
    logic [15:0] enc_y;
    logic [15:0] l_new;
    logic [15:0] k_nxt;
    logic [15:0] round_x;
    logic [15:0] round_y;
    logic        last_round;

    function automatic logic [15:0] rotr(input logic [15:0] v, input int unsigned n);
        return 16'((v >> n) | (v << (16 - n)));
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] v, input int unsigned n);
        return 16'((v << n) | (v >> (16 - n)));
    endfunction

    // Forward round and key-schedule step, shared by RUN (encrypt) and KEYEXP
    assign enc_x = (rotr(x, ALPHA) + y) ^ k;
    assign enc_y = rotl(y, BETA) ^ enc_x;
    assign l_new = (k + rotr(l0, ALPHA)) ^ {11'd0, rc};
    assign k_nxt = rotl(k, BETA) ^ l_new;

`ifdef SPECK_DECRYPT_EN
    logic        dec;
    logic [15:0] rk [ROUNDS];
    logic [15:0] k_rc;
    logic [15:0] dec_x;
    logic [15:0] dec_y;

    assign k_rc        = rk[rc];
    assign dec_y       = rotr(y ^ x, BETA);
    assign dec_x       = rotl((x ^ k_rc) - dec_y, ALPHA);
    assign round_x     = dec ? dec_x : enc_x;
    assign round_y     = dec ? dec_y : enc_y;
    assign last_round  = dec ? (rc == 5'd0) : (rc == RC_LAST);
    assign start_state = (in_dec && ROUNDS > 1) ? KEYEXP : RUN;

    // Round keys k_i are stored at index i for every operation
    always_ff @(posedge clk) begin
        case (state)
            IDLE:    if (in_valid) rk[0] <= in_key[15:0];
            KEYEXP:  rk[rc + 5'd1] <= k_nxt;
            RUN:     if (!dec) rk[rc] <= k;
            default: ;
        endcase
    end
`else
    logic dec_unused;

    assign dec_unused  = in_dec;
    assign round_x     = enc_x;
    assign round_y     = enc_y;
    assign last_round  = (rc == RC_LAST);
    assign start_state = RUN;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = start_state;
`ifdef SPECK_DECRYPT_EN
            KEYEXP:  if (rc == RC_KLAST) state_nxt = RUN;
`endif
            RUN:     if (last_round) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            k        <= '0;
            l0       <= '0;
            l1       <= '0;
            l2       <= '0;
            rc       <= '0;
            out_data <= '0;
`ifdef SPECK_DECRYPT_EN
            dec      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x  <= in_data[31:16];
                        y  <= in_data[15:0];
                        k  <= in_key[15:0];
                        l0 <= in_key[31:16];
                        l1 <= in_key[47:32];
                        l2 <= in_key[63:48];
                        rc <= '0;
`ifdef SPECK_DECRYPT_EN
                        dec <= in_dec;
`endif
                    end
                end
`ifdef SPECK_DECRYPT_EN
                KEYEXP: begin
                    k  <= k_nxt;
                    l0 <= l1;
                    l1 <= l2;
                    l2 <= l_new;
                    rc <= rc + 5'd1;
                end
`endif
                RUN: begin
                    x <= round_x;
                    y <= round_y;
`ifdef SPECK_DECRYPT_EN
                    if (dec) begin
                        if (!last_round) rc <= rc - 5'd1;
                    end else begin
                        k  <= k_nxt;
                        l0 <= l1;
                        l1 <= l2;
                        l2 <= l_new;
                        rc <= rc + 5'd1;
                    end
`else
                    k  <= k_nxt;
                    l0 <= l1;
                    l1 <= l2;
                    l2 <= l_new;
                    rc <= rc + 5'd1;
`endif
                    if (last_round) out_data <= {round_x, round_y};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_speck_round_sched.sv
// Self-checking bench for speck_round_sched: directed KAT/timing steps plus random
// blocks checked against an array-based SPECK32/64 reference model.
module tb_speck_round_sched;

    localparam int unsigned ROUNDS = 22;
    localparam int unsigned ALPHA  = 7;
    localparam int unsigned BETA   = 2;
`ifdef SPECK_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6574_694c;
    localparam logic [31:0] KAT_CT  = 32'ha868_42f2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_dec;
    logic [63:0] in_key;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    speck_round_sched #(.ROUNDS(ROUNDS), .ALPHA(ALPHA), .BETA(BETA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dec    (in_dec),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [15:0] rotr(input logic [15:0] v, input int unsigned n);
        logic [31:0] t;
        t = {v, v} >> n;
        return t[15:0];
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] v, input int unsigned n);
        return rotr(v, (16 - n) % 16);
    endfunction

    // Reference: expand the full key schedule into arrays, then apply all rounds
    function automatic logic [31:0] model(input logic dec, input logic [63:0] key, input logic [31:0] blk);
        logic [15:0] ks [ROUNDS];
        logic [15:0] ls [ROUNDS + 2];
        logic [15:0] xv;
        logic [15:0] yv;
        ks[0] = key[15:0];
        ls[0] = key[31:16];
        ls[1] = key[47:32];
        ls[2] = key[63:48];
        for (int i = 0; i < int'(ROUNDS) - 1; i++) begin
            ls[i + 3] = (ks[i] + rotr(ls[i], ALPHA)) ^ 16'(i);
            ks[i + 1] = rotl(ks[i], BETA) ^ ls[i + 3];
        end
        xv = blk[31:16];
        yv = blk[15:0];
        if (dec && DEC_EN) begin
            for (int i = int'(ROUNDS) - 1; i >= 0; i--) begin
                yv = rotr(yv ^ xv, BETA);
                xv = rotl((xv ^ ks[i]) - yv, ALPHA);
            end
        end else begin
            for (int i = 0; i < int'(ROUNDS); i++) begin
                xv = (rotr(xv, ALPHA) + yv) ^ ks[i];
                yv = rotl(yv, BETA) ^ xv;
            end
        end
        return {xv, yv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the output handshake edge
    task automatic run_op(input logic dec, input logic [63:0] key, input logic [31:0] data,
                          input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_dec    = dec;
        in_key    = key;
        in_data   = data;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_key   = {$urandom, $urandom};
        in_data  = $urandom;
        in_dec   = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("out_data", out_data, exp);
        check("busy_done", 32'(busy), 32'd1);
        check("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, exp);
            check("hold_busy", 32'(busy), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_data_held", out_data, exp);
    endtask

    initial begin
        int first;
        int second;
        logic        rdec;
        logic [63:0] rkey;
        logic [31:0] rblk;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dec    = 1'b0;
        in_key    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Encrypt KAT, then with 10 cycles of back-pressure
        run_op(1'b0, KAT_KEY, KAT_PT, KAT_CT, ROUNDS, 0);
        run_op(1'b0, KAT_KEY, KAT_PT, KAT_CT, ROUNDS, 10);

        // Back-to-back with in_valid held high
        first     = -1;
        second    = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_dec    = 1'b0;
        in_key    = KAT_KEY;
        in_data   = KAT_PT;
        for (int c = 0; c < 200 && second < 0; c++) begin
            @(posedge clk);
            #1;
            check("b2b_exclusive", 32'(out_valid & in_ready), 32'd0);
            if (out_valid === 1'b1) begin
                check("b2b_data", out_data, KAT_CT);
                if (first < 0) first = c;
                else begin
                    second   = c;
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("b2b_spacing", 32'(second - first), 32'(ROUNDS + 2));
        @(posedge clk);
        #1;
        check("b2b_idle", 32'(in_ready), 32'd1);

        // Reset at round 10 discards the block
        in_valid = 1'b1;
        in_key   = KAT_KEY;
        in_data  = KAT_PT;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst_out_valid", 32'(out_valid), 32'd0);
        run_op(1'b0, KAT_KEY, KAT_PT, KAT_CT, ROUNDS, 0);

        // in_dec=1: decrypts when built in, otherwise ignored
        if (DEC_EN) run_op(1'b1, KAT_KEY, KAT_CT, KAT_PT, 2 * ROUNDS - 1, 0);
        else        run_op(1'b1, KAT_KEY, KAT_PT, KAT_CT, ROUNDS, 0);

        for (int n = 0; n < 8; n++) begin
            rdec = 1'($urandom);
            rkey = {$urandom, $urandom};
            rblk = $urandom;
            run_op(rdec, rkey, rblk, model(rdec, rkey, rblk),
                   (rdec && DEC_EN) ? 2 * ROUNDS - 1 : ROUNDS, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/speck_round_sched.md
# speck_round_sched

Iterative SPECK32/64 engine controller: accepts a 32-bit block and 64-bit key over a valid/ready handshake, sequences one shared round datapath and the on-the-fly key schedule through all rounds, and returns the result over a second valid/ready handshake. It replaces the unrolled chain of triggered round stages with a single time-multiplexed round, and sits between the host-side block source and the ciphertext sink.

## Interface
- ROUNDS, 22, number of rounds applied (legal 1..22; 22 is standard SPECK32/64)
- ALPHA, 7, right-rotate amount on x
- BETA, 2, left-rotate amount on y
- clk  in  1  single system clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input block/key offered
- in_ready  out  1  block accepts input; high only in IDLE
- in_dec  in  1  1 = decrypt (see Configuration)
- in_key  in  64  {l2,l1,l0,k0}; k0 = in_key[15:0]
- in_data  in  32  {x,y}; x = in_data[31:16]
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_data  out  32  {x,y} result
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, KEYEXP (decrypt only), RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge: load x,y,k0,l0,l1,l2, clear round counter rc (5 bits); go RUN (encrypt) or KEYEXP (decrypt).
- RUN, encrypt, per edge: x' = ((x ror ALPHA) + y) xor k; y' = (y rol BETA) xor x'; key step l_new = (k + (l0 ror ALPHA)) xor rc; k' = (k rol BETA) xor l_new; shift l0<=l1, l1<=l2, l2<=l_new; rc++. After ROUNDS edges go DONE.
- All additions/subtractions are 16-bit modulo 2^16; carries discarded. rc xor uses zero-extended rc.
- DONE: out_valid=1, out_data={x,y} stable until out_ready sampled high; then IDLE. out_data holds last result after leaving DONE.
- in_valid ignored outside IDLE; in_data/in_key need only be stable at the accepting edge.
- Reset (any state, any time): state=IDLE, rc=0, x,y,key regs=0, out_data=0, out_valid=0, busy=0, in_ready=1. An in-flight block is discarded with no output.

## Timing
- Accept at edge T. Encrypt: out_valid rises after edge T+ROUNDS; first possible new accept at edge one cycle after the out handshake edge.
- Minimum encrypt period: ROUNDS+2 cycles per block with out_ready tied high.
- Decrypt (macro on): KEYEXP for ROUNDS-1 edges, then ROUNDS RUN edges; out_valid after edge T+2*ROUNDS-1.
- out_valid and in_ready never high in the same cycle.
- out_ready asserted before out_valid has no effect; handshake completes only on an edge where both are high.

## Configuration
- SPECK_DECRYPT_EN defined: KEYEXP state and a ROUNDS×16 round-key register file are built. Every operation stores k_i at index i. Decrypt: KEYEXP computes/stores k1..k(ROUNDS-1); RUN then applies inverse rounds with rc counting down: y' = (y xor x) ror BETA; x' = ((x xor k_rc) - y') rol ALPHA.
- SPECK_DECRYPT_EN undefined: no register file, no KEYEXP; in_dec port present but ignored (treated as 0); every operation encrypts.

## Test plan
- Encrypt KAT: in_key=64'h1918_1110_0908_0100, in_data=32'h6574_694c, out_ready=1 -> out_valid after edge T+22, out_data=32'ha868_42f2, then in_ready=1.
- Back-pressure: same KAT, out_ready=0 for 10 cycles after out_valid -> out_valid and out_data=32'ha868_42f2 held stable, busy=1, in_valid pulses ignored; release -> IDLE next edge.
- Back-to-back: two KATs with in_valid held high, out_ready=1 -> two results 24 cycles apart, both 32'ha868_42f2.
- Reset mid-run: assert rst_n=0 at round 10 -> immediately out_valid=0, busy=0, out_data=0, in_ready=1; next KAT yields 32'ha868_42f2 with full latency.
- Decrypt KAT (SPECK_DECRYPT_EN): in_dec=1, same key, in_data=32'ha868_42f2 -> out_data=32'h6574_694c after edge T+43.
- Without SPECK_DECRYPT_EN: in_dec=1 with KAT plaintext -> out_data=32'ha868_42f2 after edge T+22.
